// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo
// PS/2 keyboard receiver with prefix decoding and a scan-code FIFO behind a
// small register interface.
//   clk      system clock (rising edge)
//   rst_n    asynchronous active-low reset
//   key_clk  PS/2 clock from device (asynchronous)
//   key_din  PS/2 data from device (asynchronous)
//   cs, rd   read access when both high for one cycle
//   address  0=DATA (pops), 1=FLAGS, 2=STATUS (clears sticky errors), 3=reserved
//   dout     registered read data, holds when there is no access
//   irq      high while the FIFO is non-empty
module ps2_scan_fifo #(
  parameter int DEPTH   = 8,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_clk,
  input  logic       key_din,
  input  logic       cs,
  input  logic       rd,
  input  logic [1:0] address,
  output logic [7:0] dout,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          r_clk_s1, r_clk_s2, r_din_s1, r_din_s2;
  logic          r_kclk_f;
  logic [FW-1:0] r_filt_cnt;
  logic [10:0]   r_frame;
  logic [3:0]    r_bitcnt;
  logic          r_chk;
  logic [TW-1:0] r_to_cnt;
  logic          r_pend_ext, r_pend_brk;
  logic          r_ovf, r_par_err, r_frm_err;
  logic [AW:0]   r_wptr, r_rptr;
  logic [9:0]    r_mem [DEPTH];

  logic       w_filt_diff, w_filt_flip, w_fall, w_timeout;
  logic [7:0] w_code;
  logic       w_bad_fr, w_bad_par, w_good, w_push;
  logic       w_empty, w_full, w_acc, w_pop, w_wr, w_ovf_set, w_stat_rd;
  logic [9:0] w_head;

  // ---- synchronisers and glitch filter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_din_s1 <= 1'b1;
      r_din_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= key_clk;
      r_clk_s2 <= r_clk_s1;
      r_din_s1 <= key_din;
      r_din_s2 <= r_din_s1;
    end
  end

  // The filtered clock only follows after FILTER consecutive differing samples.
  assign w_filt_diff = (r_clk_s2 != r_kclk_f);
  assign w_filt_flip = w_filt_diff && (r_filt_cnt == FW'(FILTER - 1));
  assign w_fall      = w_filt_flip && !r_clk_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kclk_f   <= 1'b1;
      r_filt_cnt <= '0;
    end else if (!w_filt_diff || w_filt_flip) begin
      r_filt_cnt <= '0;
      if (w_filt_flip) r_kclk_f <= r_clk_s2;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // ---- frame capture and idle timeout ----
  assign w_timeout = (r_bitcnt != 4'd0) && !w_fall && (r_to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame  <= '0;
      r_bitcnt <= '0;
      r_chk    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_chk <= w_fall && (r_bitcnt == 4'd10);
      if (w_fall) begin
        r_frame  <= {r_din_s2, r_frame[10:1]};
        r_bitcnt <= (r_bitcnt == 4'd10) ? 4'd0 : r_bitcnt + 4'd1;
      end else if (w_timeout) begin
        r_bitcnt <= 4'd0;
      end
      if (r_bitcnt == 4'd0 || w_fall || w_timeout) r_to_cnt <= '0;
      else                                         r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // ---- frame check and prefix decode (cycle after the stop-bit edge) ----
  assign w_code    = r_frame[8:1];
  assign w_bad_fr  = r_chk && (r_frame[0] || !r_frame[10]);
  assign w_bad_par = r_chk && !w_bad_fr && !(^r_frame[9:1]);
  assign w_good    = r_chk && !w_bad_fr && !w_bad_par;
  assign w_push    = w_good && (w_code != 8'hE0) && (w_code != 8'hF0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_ext <= 1'b0;
      r_pend_brk <= 1'b0;
    end else if (w_bad_fr || w_bad_par || w_push) begin
      r_pend_ext <= 1'b0;
      r_pend_brk <= 1'b0;
    end else if (w_good) begin
      if (w_code == 8'hE0) r_pend_ext <= 1'b1;
      if (w_code == 8'hF0) r_pend_brk <= 1'b1;
    end
  end

  // ---- FIFO ----
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head    = w_empty ? 10'd0 : r_mem[r_rptr[AW-1:0]];
  assign w_acc     = cs && rd;
  assign w_pop     = w_acc && (address == 2'd0) && !w_empty;
  assign w_stat_rd = w_acc && (address == 2'd2);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {r_pend_ext, r_pend_brk, w_code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // ---- sticky errors: a same-cycle set wins over the STATUS-read clear ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_ovf     <= w_ovf_set | (r_ovf & !w_stat_rd);
      r_par_err <= w_bad_par | (r_par_err & !w_stat_rd);
      r_frm_err <= w_bad_fr | w_timeout | (r_frm_err & !w_stat_rd);
    end
  end

  // ---- register read port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'h00;
    end else if (w_acc) begin
      case (address)
        2'd0:    dout <= w_head[7:0];
        2'd1:    dout <= {!w_empty, w_head[8], w_head[9], 5'b0};
        2'd2:    dout <= {!w_empty, w_full, r_ovf, r_par_err, r_frm_err, 3'b0};
        default: dout <= 8'h00;
      endcase
    end
  end

  assign irq = !w_empty;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
module tb_ps2_scan_fifo;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst_n, key_clk, key_din, cs, rd;
  logic [1:0] address;
  logic [7:0] dout;
  logic       irq;
  int         total = 0;
  int         bad   = 0;

  ps2_scan_fifo #(.DEPTH(8), .FILTER(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .key_clk(key_clk), .key_din(key_din),
    .cs(cs), .rd(rd), .address(address), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bit 0 is the start bit; parity is odd over data+parity unless corrupted.
  function automatic logic [10:0] mk(input logic [7:0] c, input logic corrupt);
    logic p;
    p = (~^c) ^ corrupt;
    return {1'b1, p, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      key_din = f[i];
      wait_clk(4);
      key_clk = 1'b0;
      wait_clk(8);
      key_clk = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic send_frame(input logic [7:0] c);
    send_bits(mk(c, 1'b0), 11);
    wait_clk(6);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; address = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = dout;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    bus_rd(2'd2, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_data_empty got=%h exp=00", d); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    send_frame(8'h1C);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b exp=1", irq); end
    bus_rd(2'd1, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL basic_flags1 got=%h exp=80", d); end
    bus_rd(2'd3, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL basic_reserved got=%h exp=00", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h1C) begin bad++; $display("FAIL basic_data1 got=%h exp=1c", d); end
    bus_rd(2'd1, d);
    total++; if (d !== 8'hE0) begin bad++; $display("FAIL basic_flags2 got=%h exp=e0", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h75) begin bad++; $display("FAIL basic_data2 got=%h exp=75", d); end
    wait_clk(5);
    total++; if (dout !== 8'h75) begin bad++; $display("FAIL basic_hold got=%h exp=75", dout); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_empty got=%b exp=0", irq); end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    send_bits(mk(8'h1C, 1'b1), 11);
    wait_clk(6);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL par_irq got=%b exp=0", irq); end
    bus_rd(2'd2, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL par_status got=%h exp=10", d); end
    bus_rd(2'd2, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL par_status_clr got=%h exp=00", d); end
    // A discarded frame drops a pending E0 prefix.
    send_frame(8'hE0);
    send_bits(mk(8'h33, 1'b1), 11);
    wait_clk(6);
    send_frame(8'h75);
    bus_rd(2'd1, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL par_pend_clr got=%h exp=80", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h75) begin bad++; $display("FAIL par_data got=%h exp=75", d); end
    bus_rd(2'd2, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL par_status2 got=%h exp=10", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i));
    bus_rd(2'd2, d);
    total++; if (d !== 8'hE0) begin bad++; $display("FAIL ovf_status got=%h exp=e0", d); end
    for (int i = 0; i < 8; i++) begin
      bus_rd(2'd0, d);
      total++; if (d !== 8'h10 + 8'(i)) begin bad++; $display("FAIL ovf_data%0d got=%h exp=%h", i, d, 8'h10 + 8'(i)); end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovf_irq got=%b exp=0", irq); end
    bus_rd(2'd2, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL ovf_status_clr got=%h exp=00", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL ovf_data_empty got=%h exp=00", d); end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    send_bits(mk(8'h29, 1'b0), 4);
    wait_clk(TO + 20);
    send_frame(8'h29);
    bus_rd(2'd2, d);
    total++; if (d !== 8'h88) begin bad++; $display("FAIL to_status got=%h exp=88", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h29) begin bad++; $display("FAIL to_data got=%h exp=29", d); end
  endtask

  task automatic test_glitch();
    logic [10:0] f;
    logic [7:0]  d;
    f = mk(8'h3A, 1'b0);
    send_bits(f, 3);
    key_clk = 1'b0;
    wait_clk(2);
    key_clk = 1'b1;
    wait_clk(6);
    for (int i = 3; i < 11; i++) begin
      key_din = f[i];
      wait_clk(4);
      key_clk = 1'b0;
      wait_clk(8);
      key_clk = 1'b1;
      wait_clk(4);
    end
    wait_clk(6);
    bus_rd(2'd2, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL glitch_status got=%h exp=80", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h3A) begin bad++; $display("FAIL glitch_data got=%h exp=3a", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    send_frame(8'hE0);
    send_bits(mk(8'hC3, 1'b0), 6);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    send_frame(8'h5A);
    bus_rd(2'd2, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL rstmid_status got=%h exp=80", d); end
    bus_rd(2'd1, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL rstmid_flags got=%h exp=80", d); end
    bus_rd(2'd0, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL rstmid_data got=%h exp=5a", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
  endtask

  initial begin
    rst_n = 1'b0; key_clk = 1'b1; key_din = 1'b1;
    cs = 1'b0; rd = 1'b0; address = 2'd0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
